// File: rtl/pwm_duty_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pwm_duty_sequencer
// Description : PWM period counter with a handshake-loaded duty target that is
//               ramped in steps, updating duty only at period boundaries.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_duty_sequencer #(
    parameter int CNT_W    = 8,
    parameter int PERIOD   = 100,
    parameter int STEP_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_target,
    input  logic [CNT_W-1:0] cfg_step,
    output logic             out,
    output logic [CNT_W-1:0] counter,
    output logic [CNT_W-1:0] duty,
    output logic             busy,
    output logic             period_tick
);

    localparam logic [CNT_W-1:0] c_LAST     = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] c_PERIOD   = CNT_W'(PERIOD);
    localparam int               c_DIV_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(STEP_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_counter;
    logic [CNT_W-1:0]   r_duty;
    logic [CNT_W-1:0]   r_target;
    logic [CNT_W-1:0]   r_step;
    logic [c_DIV_W-1:0] r_div_cnt;

    logic               w_accept;
    logic               w_tick;
    logic [CNT_W-1:0]   w_tgt_clamped;
    logic [CNT_W-1:0]   w_step_eff;
    logic [CNT_W:0]     w_sum;
    logic [CNT_W:0]     w_tgt_plus_step;
    logic [CNT_W-1:0]   w_up;
    logic [CNT_W-1:0]   w_down;
    logic [CNT_W-1:0]   w_duty_next;

    assign w_tick    = enable && (r_counter == c_LAST);
    assign cfg_ready = !rst && (r_state != ST_RAMP);
    assign w_accept  = cfg_valid && cfg_ready;

    assign w_tgt_clamped = (cfg_target > c_PERIOD) ? c_PERIOD : cfg_target;
    assign w_step_eff    = (cfg_step == '0) ? CNT_W'(1) : cfg_step;

    // One extra bit so duty+step and target+step cannot wrap before comparison
    assign w_sum           = {1'b0, r_duty} + {1'b0, r_step};
    assign w_tgt_plus_step = {1'b0, r_target} + {1'b0, r_step};
    assign w_up            = (w_sum > {1'b0, r_target}) ? r_target : w_sum[CNT_W-1:0];
    assign w_down          = ({1'b0, r_duty} > w_tgt_plus_step) ? (r_duty - r_step) : r_target;
    assign w_duty_next     = (r_target > r_duty) ? w_up : w_down;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_counter <= '0;
            r_duty    <= '0;
            r_target  <= '0;
            r_step    <= CNT_W'(1);
            r_div_cnt <= '0;
            r_state   <= ST_IDLE;
        end else begin
            if (!enable)
                r_counter <= '0;
            else if (r_counter == c_LAST)
                r_counter <= '0;
            else
                r_counter <= r_counter + CNT_W'(1);

            if (w_accept) begin
                r_target  <= w_tgt_clamped;
                r_step    <= w_step_eff;
                r_div_cnt <= '0;
                r_state   <= (w_tgt_clamped != r_duty) ? ST_RAMP : ST_HOLD;
            end else if ((r_state == ST_RAMP) && w_tick) begin
                if (r_div_cnt != c_DIV_LAST) begin
                    r_div_cnt <= r_div_cnt + c_DIV_W'(1);
                end else begin
                    r_div_cnt <= '0;
                    r_duty    <= w_duty_next;
                    if (w_duty_next == r_target)
                        r_state <= ST_HOLD;
                end
            end
        end
    end

    assign out         = enable && (r_counter < r_duty);
    assign counter     = r_counter;
    assign duty        = r_duty;
    assign busy        = (r_state == ST_RAMP);
    assign period_tick = w_tick;

endmodule
`default_nettype wire

// File: doc/pwm_duty_sequencer.md
Name: pwm_duty_sequencer

Overview:
Controller that owns a PWM period counter and sequences the duty-cycle compare value feeding the PWM output. It accepts a new target duty over a valid/ready handshake and ramps the active duty toward that target in programmable steps. Duty changes only at period boundaries, so the output never shows a glitched or partial period. It sits between the control logic and the PWM output pin and replaces fixed-duty generation.

Parameters:
CNT_W, 8, width of the period counter, duty and config fields; must satisfy 2^CNT_W > PERIOD
PERIOD, 100, counts per PWM period; counter runs 0..PERIOD-1
STEP_DIV, 4, number of completed periods between ramp steps; must be >= 1

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, synchronous, active-high
enable  input  1  1 = counter runs and output is active; 0 = pause
cfg_valid  input  1  new configuration offered
cfg_ready  output  1  configuration can be accepted this cycle
cfg_target  input  CNT_W  target duty in counts
cfg_step  input  CNT_W  ramp increment per step in counts
out  output  1  PWM output
counter  output  CNT_W  current period counter value
duty  output  CNT_W  active duty compare value
busy  output  1  ramp in progress
period_tick  output  1  one-cycle pulse on the last count of a period

Behaviour:
- Reset (rst=1 at a clk edge) sets: counter=0, duty=0, target=0, step=1, div_cnt=0, state=IDLE. Outputs after reset: out=0, busy=0, period_tick=0. cfg_ready=0 while rst=1, and 1 on the first cycle after rst is released.
- Reset during a ramp abandons the ramp with no residue. Any cfg_valid in a reset cycle is ignored.
- Period counter:
  - When enable=1, counter increments each cycle and wraps from PERIOD-1 to 0.
  - When enable=0, counter is forced to 0 on the next edge.
- period_tick = enable && (counter == PERIOD-1). It is combinational.
- out = enable && (counter < duty). It is combinational, with no added latency.
  - duty=0 gives a constant 0.
  - duty=PERIOD gives a constant 1.
- The FSM has three states: IDLE, RAMP and HOLD.
- cfg_ready = !rst && (state != RAMP). A handshake completes on a cycle where cfg_valid && cfg_ready.
- On accept:
  - The target is latched as min(cfg_target, PERIOD), so targets above PERIOD are clamped.
  - The step is latched as cfg_step, except that cfg_step=0 is latched as 1.
  - div_cnt is cleared to 0.
  - Next state is RAMP if the clamped target differs from duty, otherwise HOLD.
- RAMP:
  - On each period_tick, if div_cnt < STEP_DIV-1 then div_cnt increments.
  - Otherwise div_cnt is cleared and duty moves one step toward the target:
    - Upward: duty = min(duty+step, target).
    - Downward: duty = (duty > target+step) ? duty-step : target.
  - Compute with CNT_W+1 bits so the intermediate result does not overflow. Duty never overshoots the target.
  - Because the update is registered on the period_tick edge, the new duty takes effect from counter=0 of the next period.
  - When the updated duty equals the target, the next state is HOLD.
- A period_tick in the same cycle as a config accept is not counted toward div_cnt.
- HOLD and IDLE: duty is constant and a new configuration can be accepted. HOLD differs from IDLE only in that at least one config has been accepted.
- busy = (state == RAMP).
- enable=0 during RAMP:
  - The ramp freezes: duty, target and div_cnt are held, and no period_tick occurs.
  - The ramp resumes from the frozen point after enable returns to 1.
- cfg_valid while in RAMP is ignored (cfg_ready=0). The source must hold the request until cfg_ready=1.

Test Plan:
1. Reset. Hold rst=1 with enable=1 and cfg_valid=1 for 3 cycles, then release -> out=0, duty=0, counter=0, busy=0. The config is not taken during reset, and cfg_ready=1 on the first cycle after release.
2. Up ramp. Defaults, enable=1, accept target=20 step=5 at counter=0 -> duty becomes 5 at the 4th period_tick, then 10, 15, 20 at every 4th tick. busy drops on the 16th tick. Afterwards out is high for counter 0..19 of each 100-cycle period.
3. Down ramp with partial final step. Accept target=3 step=5 from HOLD at duty=20 -> duty goes 15, 10, 5, 3, then HOLD. out is high for 3 cycles per period.
4. Clamp and zero step. Accept target=150 step=0 from duty=98 -> target is clamped to 100 and step is forced to 1. duty goes 99, then 100, and out is constant 1 thereafter. Then accept target=0 step=100 -> duty=0 after 4 ticks, and out is constant 0.
5. Busy and pause. Assert cfg_valid mid-ramp -> cfg_ready=0 and the request is ignored until HOLD. Drop enable for 250 cycles mid-ramp -> out=0, counter=0, no ticks, and duty and div_cnt held. Re-enable -> the ramp continues with the remaining div_cnt count.
6. Edge cases. Accept in the cycle of a period_tick -> that tick is not counted, and the first step lands 4 ticks later. Assert rst mid-ramp at duty=10 -> duty=0 and the state returns to IDLE.
